// File: rtl/sample_fifo_ctrl.sv
// FIFO controller for the 1024x9 sample RAM: push side writes straight to RAM,
// pop side absorbs the RAM's one-cycle read latency with a 2-entry output buffer.
module sample_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 9,
  parameter int unsigned AFULL_LEVEL = 1008
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int unsigned LW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LW-1:0] AFULL = LW'(AFULL_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count, mem_count_next;
  logic                  inflight;
  logic [1:0]            obuf_count, obuf_count_next;
  logic [DATA_WIDTH-1:0] obuf_head, obuf_tail, head_next, tail_next;
  logic                  push, pop, issue;
  logic [2:0]            occ_after_pop;
  logic [LW-1:0]         level_next;

  assign in_ready    = (mem_count < DEPTH);
  assign out_valid   = (obuf_count != 2'd0);
  assign out_data    = obuf_head;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = rd_ptr;

  // Only issue a read when the output buffer is guaranteed a free slot for it
  assign occ_after_pop = 3'(obuf_count) + 3'(inflight) - 3'(pop);
  assign issue         = (mem_count != '0) && (occ_after_pop < 3'd2);

  always_comb begin
    mem_count_next  = mem_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    head_next       = obuf_head;
    tail_next       = obuf_tail;
    obuf_count_next = obuf_count;
    if (pop) begin
      head_next       = obuf_tail;
      obuf_count_next = obuf_count - 2'd1;
    end
    // Capture lands in whichever slot is the tail after the pop has shifted
    if (inflight) begin
      if (obuf_count_next == 2'd0) head_next = ram_rd_data;
      else                         tail_next = ram_rd_data;
      obuf_count_next = obuf_count_next + 2'd1;
    end
    level_next = LW'(mem_count_next) + LW'(issue) + LW'(obuf_count_next);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      inflight    <= 1'b0;
      obuf_count  <= '0;
      obuf_head   <= '0;
      obuf_tail   <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      mem_count   <= mem_count_next;
      inflight    <= issue;
      obuf_count  <= obuf_count_next;
      obuf_head   <= head_next;
      obuf_tail   <= tail_next;
      level       <= level_next;
      almost_full <= (level_next >= AFULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                      overflow <= 1'b0;
    else if (!flush && in_valid && !in_ready)     overflow <= 1'b1;
  end

endmodule
